// File: rtl/telem_ft_framer.sv
// Packet-to-FT245 framer: queues 88-bit telemetry packets and emits each one as
// eight 16-bit words on the ft user write port, honouring ui_din_full backpressure.
module telem_ft_framer #(
  parameter int unsigned PKT_DEPTH = 4,
  parameter logic [7:0]  MARK      = 8'h7C,
  parameter logic [15:0] SYNC0     = 16'hF00D,
  parameter logic [15:0] SYNC1     = 16'hC0DE,
  parameter logic [15:0] IDLE_WORD = 16'h00BC
) (
  input  logic                         clk_128M,
  input  logic                         rst_n,
  input  logic [87:0]                  packet_data,
  input  logic                         packet_valid,
  output logic [15:0]                  ui_din,
  output logic [1:0]                   ui_din_be,
  output logic                         ui_din_valid,
  input  logic                         ui_din_full,
  output logic [$clog2(PKT_DEPTH):0]   fifo_level,
  output logic                         busy,
  output logic [15:0]                  drop_count
);

  localparam int unsigned AW = $clog2(PKT_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [87:0]   mem_q [PKT_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [15:0]   drop_q;

  state_t        state_q;
  logic [2:0]    idx_q;
  logic [87:0]   frame_q;
  logic [15:0]   din_q;
  logic          valid_q;

  logic          fifo_full, fifo_empty, xfer, push, pop;
  logic [87:0]   head;

  function automatic logic [15:0] frame_word(input logic [87:0] d, input logic [2:0] i);
    case (i)
      3'd0:    frame_word = d[15:0];
      3'd1:    frame_word = d[31:16];
      3'd2:    frame_word = d[47:32];
      3'd3:    frame_word = d[63:48];
      3'd4:    frame_word = d[79:64];
      3'd5:    frame_word = {MARK, d[87:80]};
      3'd6:    frame_word = SYNC0;
      default: frame_word = SYNC1;
    endcase
  endfunction

  // Full/empty come from the registered level, so a same-cycle pop never admits a push
  // and a same-cycle push is never popped before it is visible.
  always_comb begin
    fifo_full  = (level_q == LW'(PKT_DEPTH));
    fifo_empty = (level_q == '0);
    xfer       = valid_q && !ui_din_full;
    push       = packet_valid && !fifo_full;
    pop        = !fifo_empty && ((state_q == IDLE) || (xfer && idx_q == 3'd7));
    head       = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_128M) begin
    if (push) mem_q[wr_ptr_q] <= packet_data;
  end

  always_ff @(posedge clk_128M) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (packet_valid && fifo_full && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_128M) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      din_q   <= IDLE_WORD;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            frame_q <= head;
            idx_q   <= '0;
            din_q   <= frame_word(head, 3'd0);
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx_q != 3'd7) begin
              idx_q <= idx_q + 3'd1;
              din_q <= frame_word(frame_q, idx_q + 3'd1);
            end else if (pop) begin
              frame_q <= head;
              idx_q   <= '0;
              din_q   <= frame_word(head, 3'd0);
            end else begin
              idx_q   <= '0;
              din_q   <= IDLE_WORD;
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ui_din       = din_q;
  assign ui_din_be    = 2'b11;
  assign ui_din_valid = valid_q;
  assign fifo_level   = level_q;
  assign busy         = (state_q == SEND);
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_telem_ft_framer.sv
// Bench for telem_ft_framer: directed scenarios plus random traffic, each cycle
// compared against a queue-based model of packets waiting and words left in flight.
module tb_telem_ft_framer;

  localparam int unsigned DEPTH = 4;

  logic        clk_128M = 1'b0;
  logic        rst_n = 1'b0;
  logic [87:0] packet_data = '0;
  logic        packet_valid = 1'b0;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full = 1'b0;
  logic [2:0]  fifo_level;
  logic        busy;
  logic [15:0] drop_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [87:0] mq[$];
  logic [15:0] cur[$];
  int unsigned mdrop = 0;

  telem_ft_framer #(.PKT_DEPTH(DEPTH)) dut (
    .clk_128M(clk_128M), .rst_n(rst_n), .packet_data(packet_data),
    .packet_valid(packet_valid), .ui_din(ui_din), .ui_din_be(ui_din_be),
    .ui_din_valid(ui_din_valid), .ui_din_full(ui_din_full), .fifo_level(fifo_level),
    .busy(busy), .drop_count(drop_count));

  always #4 clk_128M = ~clk_128M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [87:0] rand_pkt();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Behavioural model: packet queue, remaining words of the frame on the wire, drop tally.
  task automatic model_edge(input logic pv, input logic [87:0] pd, input logic full,
                            input logic rstn);
    int unsigned old;
    logic [87:0] p;
    if (!rstn) begin
      mq.delete();
      cur.delete();
      mdrop = 0;
      return;
    end
    old = mq.size();
    if (cur.size() != 0 && !full) void'(cur.pop_front());
    if (cur.size() == 0 && old > 0) begin
      p = mq.pop_front();
      for (int i = 0; i < 5; i++) cur.push_back(p[16*i +: 16]);
      cur.push_back({8'h7C, p[87:80]});
      cur.push_back(16'hF00D);
      cur.push_back(16'hC0DE);
    end
    if (pv) begin
      if (old < DEPTH) mq.push_back(pd);
      else if (mdrop < 65535) mdrop++;
    end
  endtask

  task automatic step(input logic pv, input logic [87:0] pd, input logic full,
                      input logic rstn);
    logic        ev;
    @(negedge clk_128M);
    packet_valid = pv;
    packet_data  = pd;
    ui_din_full  = full;
    rst_n        = rstn;
    @(posedge clk_128M);
    model_edge(pv, pd, full, rstn);
    #1;
    ev = (cur.size() != 0);
    check("ui_din_valid", 32'(ui_din_valid), 32'(ev));
    check("ui_din", 32'(ui_din), ev ? 32'(cur[0]) : 32'h00BC);
    check("busy", 32'(busy), 32'(ev));
    check("fifo_level", 32'(fifo_level), mq.size());
    check("drop_count", 32'(drop_count), mdrop);
    check("ui_din_be", 32'(ui_din_be), 32'h3);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [87:0] pk;
    int unsigned held;

    do_reset();
    do_reset();

    // Single packet, no backpressure
    step(1'b1, 88'hAABB_CCDD_EEFF_0011_2233_44, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Backpressure for 5 cycles while w3 is offered
    held = 0;
    step(1'b1, 88'hAABB_CCDD_EEFF_0011_2233_44, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (cur.size() == 5 && held < 5) begin
        held++;
        step(1'b0, '0, 1'b1, 1'b1);
      end else step(1'b0, '0, 1'b0, 1'b1);
    end
    check("w3_hold_cycles", held, 5);

    // Two strobes 3 cycles apart -> back-to-back frames
    for (int i = 0; i < 22; i++)
      step(i == 0 || i == 3, rand_pkt(), 1'b0, 1'b1);

    // Overflow with full held, then drain
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, rand_pkt(), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_drops", 32'(drop_count), 32'd1);
    for (int i = 0; i < 50; i++) step(1'b0, '0, 1'b0, 1'b1);

    // drop_count saturation
    do_reset();
    for (int i = 0; i < 65545; i++) step(1'b1, rand_pkt(), 1'b1, 1'b1);
    check("drop_sat", 32'(drop_count), 32'hFFFF);
    for (int i = 0; i < 45; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Reset during w4 with two packets queued
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rand_pkt(), 1'b0, 1'b1);
    for (int i = 0; i < 20 && cur.size() != 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("reached_w4", cur.size(), 4);
    step(1'b0, '0, 1'b0, 1'b0);
    pk = rand_pkt();
    step(1'b1, pk, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("post_rst_w0", 32'(ui_din), 32'(pk[15:0]));
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(9, 0) < 4, rand_pkt(), $urandom_range(9, 0) < 3,
           $urandom_range(199, 0) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
